// File: rtl/gemm_job_scheduler.sv
// gemm_job_scheduler: queues GEMM jobs and issues them one at a time to the systolic controller. Rev 1.0
// Define JOB_SCHED_PERF_EN to add the rsp_cycles per-job latency port.
`default_nettype none

module gemm_job_scheduler #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_k,
  input  logic [7:0]             cmd_m,
  input  logic [7:0]             cmd_n,
  input  logic [ID_W-1:0]        cmd_id,
  output logic                   ctl_in_valid,
  output logic [7:0]             ctl_k,
  output logic [7:0]             ctl_m,
  output logic [7:0]             ctl_n,
  input  logic                   ctl_busy,
  input  logic                   ctl_complete,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   idle
`ifdef JOB_SCHED_PERF_EN
  ,
  output logic [31:0]            rsp_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem_k  [DEPTH];
  logic [7:0]      mem_m  [DEPTH];
  logic [7:0]      mem_n  [DEPTH];
  logic [ID_W-1:0] mem_id [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head_bad;

  assign empty     = (count == '0);
  // No bypass: a full FIFO refuses even when a pop happens this cycle.
  assign cmd_ready = (count != FULL_LEVEL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty && !ctl_busy;
  assign head_bad  = (mem_k[rd_ptr] == 8'd0) || (mem_m[rd_ptr] == 8'd0) ||
                     (mem_n[rd_ptr] == 8'd0);
  assign q_level   = count;
  assign idle      = (state == S_IDLE) && empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_k[wr_ptr]  <= cmd_k;
      mem_m[wr_ptr]  <= cmd_m;
      mem_n[wr_ptr]  <= cmd_n;
      mem_id[wr_ptr] <= cmd_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef JOB_SCHED_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] cyc_inc;
  assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ctl_in_valid <= 1'b0;
      ctl_k        <= '0;
      ctl_m        <= '0;
      ctl_n        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
`ifdef JOB_SCHED_PERF_EN
      cyc_cnt      <= '0;
      rsp_cycles   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            rsp_id <= mem_id[rd_ptr];
            if (head_bad) begin
              // Rejected jobs never reach the controller; dims stay as last issued.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
`ifdef JOB_SCHED_PERF_EN
              rsp_cycles <= '0;
`endif
            end else begin
              state        <= S_ISSUE;
              ctl_in_valid <= 1'b1;
              ctl_k        <= mem_k[rd_ptr];
              ctl_m        <= mem_m[rd_ptr];
              ctl_n        <= mem_n[rd_ptr];
            end
          end
        end
        S_ISSUE: begin
          ctl_in_valid <= 1'b0;
          state        <= S_RUN;
`ifdef JOB_SCHED_PERF_EN
          cyc_cnt      <= 32'd1;
`endif
        end
        S_RUN: begin
`ifdef JOB_SCHED_PERF_EN
          cyc_cnt <= cyc_inc;
`endif
          if (ctl_complete) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
`ifdef JOB_SCHED_PERF_EN
            rsp_cycles <= cyc_inc;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gemm_job_scheduler.sv
// Scoreboard bench for gemm_job_scheduler: expected issues/responses queued at push, checked by a monitor.
`default_nettype none

module tb_gemm_job_scheduler;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_k, cmd_m, cmd_n;
  logic [ID_W-1:0] cmd_id;
  logic            ctl_in_valid;
  logic [7:0]      ctl_k, ctl_m, ctl_n;
  logic            ctl_busy;
  logic            ctl_complete;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_err;
  logic [2:0]      q_level;
  logic            idle;
`ifdef JOB_SCHED_PERF_EN
  logic [31:0]     rsp_cycles;
`endif

  always #5 clk = ~clk;

  gemm_job_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_k        (cmd_k),
    .cmd_m        (cmd_m),
    .cmd_n        (cmd_n),
    .cmd_id       (cmd_id),
    .ctl_in_valid (ctl_in_valid),
    .ctl_k        (ctl_k),
    .ctl_m        (ctl_m),
    .ctl_n        (ctl_n),
    .ctl_busy     (ctl_busy),
    .ctl_complete (ctl_complete),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .q_level      (q_level),
    .idle         (idle)
`ifdef JOB_SCHED_PERF_EN
    ,
    .rsp_cycles   (rsp_cycles)
`endif
  );

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] m;
    logic [7:0] n;
  } iss_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
    logic [31:0]     cyc;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                          input logic [ID_W-1:0] id, input logic [31:0] cyc,
                          input bit exp_issue, input bit exp_rsp);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_k = k; cmd_m = m; cmd_n = n; cmd_id = id;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (!cmd_ready) begin
      fail("push_timeout");
    end else begin
      if (exp_issue) iss_q.push_back('{k: k, m: m, n: n});
      if (exp_rsp) rsp_q.push_back('{id: id, err: (k == 0 || m == 0 || n == 0), cyc: cyc});
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  // Controller model: waits for the start pulse, stays busy lat cycles, pulses complete,
  // then keeps busy asserted tail more cycles.
  task automatic ctl_serve(input int lat, input int tail);
    int w = 0;
    while (!ctl_in_valid && w < 300) begin
      tick();
      w++;
    end
    if (!ctl_in_valid) begin
      fail("issue_timeout");
    end else begin
      ctl_busy = 1'b1;
      repeat (lat) tick();
      ctl_complete = 1'b1;
      tick();
      ctl_complete = 1'b0;
      repeat (tail) tick();
      ctl_busy = 1'b0;
    end
  endtask

  task automatic monitor();
    logic            prev_busy = 1'b0;
    logic            hold_v = 1'b0;
    logic [ID_W-1:0] hold_id = '0;
    logic            hold_err = 1'b0;
    iss_t            ei;
    rsp_t            er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        hold_v    = 1'b0;
      end else begin
        check("ready_vs_level", cmd_ready, (q_level != 3'(DEPTH)));
        if (ctl_in_valid) begin
          check("issue_while_busy", prev_busy, 0);
          if (iss_q.size() == 0) begin
            fail("unexpected_issue");
          end else begin
            ei = iss_q.pop_front();
            check("ctl_dims", {ctl_k, ctl_m, ctl_n}, ei);
          end
        end
        if (hold_v) begin
          check("rsp_held_valid", rsp_valid, 1);
          check("rsp_held_id", rsp_id, hold_id);
          check("rsp_held_err", rsp_err, hold_err);
        end
        if (rsp_valid && rsp_ready) begin
          hold_v = 1'b0;
          if (rsp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            er = rsp_q.pop_front();
            check("rsp_id", rsp_id, er.id);
            check("rsp_err", rsp_err, er.err);
`ifdef JOB_SCHED_PERF_EN
            check("rsp_cycles", rsp_cycles, er.cyc);
`endif
          end
        end else if (rsp_valid) begin
          hold_v   = 1'b1;
          hold_id  = rsp_id;
          hold_err = rsp_err;
        end
        prev_busy = ctl_busy;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_q_level"}, q_level, 0);
    check({tag, "_in_valid"}, ctl_in_valid, 0);
    check({tag, "_ctl_dims"}, {ctl_k, ctl_m, ctl_n}, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id_err"}, {rsp_id, rsp_err}, 0);
`ifdef JOB_SCHED_PERF_EN
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_k = '0; cmd_m = '0; cmd_n = '0; cmd_id = '0;
    ctl_busy = 1'b0; ctl_complete = 1'b0; rsp_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // 1: single job, latency and cycle count
    push_job(8'd7, 8'd6, 8'd5, 4'd3, 32'd41, 1, 1);
    check("t1_no_early_issue", ctl_in_valid, 0);
    tick();
    check("t1_issue_t2", ctl_in_valid, 1);
    ctl_serve(40, 0);
    check("t1_rsp_latency", rsp_valid, 1);
    repeat (3) tick();

    // 2: five jobs into a four-entry FIFO with a slow controller
    fork
      begin
        for (int i = 1; i <= 5; i++)
          push_job(8'(i), 8'(i + 1), 8'(i + 2), 4'(i), 32'd21, 1, 1);
        check("t2_q_peak", q_level, 4);
        check("t2_full_not_ready", cmd_ready, 0);
      end
      begin
        repeat (5) ctl_serve(20, 0);
      end
    join
    repeat (3) tick();

    // 3: zero dimension is rejected without issue
    push_job(8'd0, 8'd4, 8'd4, 4'd9, 32'd0, 0, 1);
    push_job(8'd4, 8'd4, 8'd4, 4'd10, 32'd6, 1, 1);
    ctl_serve(5, 0);
    repeat (3) tick();

    // 4: response back-pressure holds the next job
    rsp_ready = 1'b0;
    push_job(8'd2, 8'd3, 8'd4, 4'd11, 32'd4, 1, 1);
    push_job(8'd5, 8'd6, 8'd7, 4'd12, 32'd4, 1, 1);
    ctl_serve(3, 0);
    for (int i = 0; i < 10; i++) begin
      check("t4_rsp_pending", rsp_valid, 1);
      check("t4_no_second_issue", ctl_in_valid, 0);
      tick();
    end
    check("t4_q_level", q_level, 1);
    rsp_ready = 1'b1;
    ctl_serve(3, 0);
    repeat (3) tick();

    // 5: busy lingers after complete; spurious complete in idle
    push_job(8'd1, 8'd1, 8'd1, 4'd13, 32'd5, 1, 1);
    push_job(8'd9, 8'd8, 8'd7, 4'd14, 32'd5, 1, 1);
    ctl_serve(4, 3);
    check("t5_wait_busy", ctl_in_valid, 0);
    tick();
    check("t5_issue_after_busy", ctl_in_valid, 1);
    ctl_serve(4, 0);
    repeat (3) tick();
    check("t5_idle_before_spur", idle, 1);
    ctl_complete = 1'b1;
    tick();
    ctl_complete = 1'b0;
    repeat (5) tick();
    check("t5_spur_no_rsp", rsp_valid, 0);
    check("t5_idle_after_spur", idle, 1);

    // 6: reset while running with three queued jobs
    fork
      begin
        push_job(8'd3, 8'd3, 8'd3, 4'd1, 32'd0, 1, 0);
        push_job(8'd4, 8'd4, 8'd4, 4'd2, 32'd0, 0, 0);
        push_job(8'd5, 8'd5, 8'd5, 4'd4, 32'd0, 0, 0);
        push_job(8'd6, 8'd6, 8'd6, 4'd5, 32'd0, 0, 0);
      end
      begin
        int w = 0;
        while (!ctl_in_valid && w < 50) begin
          tick();
          w++;
        end
        if (!ctl_in_valid) fail("t6_issue_timeout");
        else ctl_busy = 1'b1;
      end
    join
    tick();
    check("t6_q_level_pre", q_level, 3);
    check("t6_running", idle, 0);
    #2;
    rst_n = 1'b0;
    ctl_busy = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("t6_no_rsp", rsp_valid, 0);
    check("t6_no_issue", ctl_in_valid, 0);
    check("t6_idle", idle, 1);

    check("rsp_q_drained", rsp_q.size(), 0);
    check("iss_q_drained", iss_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
